// File: rtl/l0_pkg.sv
// l0_pkg: shared constants and the requantize helper for the layer-0 pooling
// stage. N_WIN is the number of 2x2 windows per 13x13 pooled map.
// POOL_BEATS is the number of samples in one window.
package l0_pkg;

  localparam int unsigned N_WIN      = 169;
  localparam int unsigned DW         = 18;
  localparam int unsigned OW         = 8;
  localparam int unsigned POOL_BEATS = 4;

  // Shift right, then clamp to the largest OW-bit value.
  function automatic logic [OW-1:0] requant(input logic [DW-1:0] m,
                                            input int unsigned   shift);
    logic [DW-1:0] q;
    q = m >> shift;
    if (q > {{(DW-OW){1'b0}}, {OW{1'b1}}}) begin
      return '1;
    end
    return q[OW-1:0];
  endfunction

endpackage

// File: rtl/l0_pool_buf.sv
// l0_pool_buf: simple dual-port pooled-map buffer, DEPTH x W.
//   clk            clock
//   clr            synchronous clear of the read output register only
//   we/waddr/wdata registered write port
//   re/raddr       read request; the caller has already qualified it
//   rd_vld/rdata   registered read result; rdata is 0 when rd_vld is low
// The array has no reset, so its contents are undefined until written.
module l0_pool_buf #(
  parameter int unsigned DEPTH = 169,
  parameter int unsigned W     = 16,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic          rd_vld,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_vld <= 1'b0;
      rdata  <= '0;
    end else begin
      rd_vld <= re;
      rdata  <= re ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/l0_pool.sv
// l0_pool: 2x2 max-pool of layer-0 channels 0 and 1.
// The block takes four beats per window, requantizes the maximum to OW bits
// and stores it in a 13x13 buffer. Layer 1 reads that buffer by address.
//   clk, rst_n      clock, synchronous active-low reset
//   tx_done         end-of-image pulse. It acts as a reset for all registers
//                   but leaves the buffer contents in place.
//   vld_in          din_0/din_1 carry one window sample
//   rd_en/rd_addr   read request. The result appears one cycle later on
//                   dout_0/dout_1/rd_vld.
//   wr_cnt          number of windows written
//   bsy             a window is partially accumulated
//   done            all N_WIN windows have been written
//   ovf             sticky: vld_in arrived while done
module l0_pool #(
  parameter int unsigned DW    = 18,
  parameter int unsigned OW    = 8,
  parameter int unsigned SHIFT = 4,
  parameter int unsigned N_WIN = 169,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tx_done,
  input  logic          vld_in,
  input  logic [DW-1:0] din_0,
  input  logic [DW-1:0] din_1,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [OW-1:0] dout_0,
  output logic [OW-1:0] dout_1,
  output logic          rd_vld,
  output logic [AW-1:0] wr_cnt,
  output logic          bsy,
  output logic          done,
  output logic          ovf
);

  import l0_pkg::*;

  logic [1:0]      beat;
  logic [DW-1:0]   max_0, max_1;
  logic [DW-1:0]   m_0, m_1;
  logic            clr, take, last, we, rd_ok;
  logic [2*OW-1:0] wdata, rdata;

  assign clr  = !rst_n || tx_done;
  assign take = vld_in && !done;
  assign last = take && (beat == 2'(POOL_BEATS - 1));

  // The running maximum including the current beat. On beat 3 this is the
  // final window maximum, and it is written on the same edge.
  assign m_0 = (din_0 > max_0) ? din_0 : max_0;
  assign m_1 = (din_1 > max_1) ? din_1 : max_1;

  assign wdata = {requant(m_1, SHIFT), requant(m_0, SHIFT)};
  assign we    = last && !clr;

  // The comparison uses wr_cnt before the edge. A read of the slot being
  // written in this cycle is therefore reported invalid, and there is no
  // bypass path.
  assign rd_ok = rd_en && (rd_addr < wr_cnt) && !clr;

  assign bsy = (beat != '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      beat   <= '0;
      max_0  <= '0;
      max_1  <= '0;
      wr_cnt <= '0;
      done   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (take) begin
        beat <= beat + 2'd1;
        if (beat == '0) begin
          max_0 <= din_0;
          max_1 <= din_1;
        end else begin
          max_0 <= m_0;
          max_1 <= m_1;
        end
        if (last) begin
          wr_cnt <= wr_cnt + AW'(1);
          if (wr_cnt == AW'(N_WIN - 1)) begin
            done <= 1'b1;
          end
        end
      end
      if (vld_in && done) begin
        ovf <= 1'b1;
      end
    end
  end

  l0_pool_buf #(
    .DEPTH (N_WIN),
    .W     (2 * OW),
    .AW    (AW)
  ) u_buf (
    .clk    (clk),
    .clr    (clr),
    .we     (we),
    .waddr  (wr_cnt),
    .wdata  (wdata),
    .re     (rd_ok),
    .raddr  (rd_addr),
    .rd_vld (rd_vld),
    .rdata  (rdata)
  );

  assign dout_0 = rdata[OW-1:0];
  assign dout_1 = rdata[2*OW-1:OW];

endmodule

// File: tb/tb_l0_pool.sv
// tb_l0_pool: two l0_pool instances share the same stimulus. u_s0 uses
// SHIFT=0 and u_s4 uses SHIFT=4. A behavioural model keeps the raw window
// maxima. Each read request pushes its expected result into a scoreboard
// queue, and the negedge monitor pops from it and compares.
module tb_l0_pool;

  localparam int unsigned DW    = 18;
  localparam int unsigned OW    = 8;
  localparam int unsigned N_WIN = 169;
  localparam int unsigned AW    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, tx_done, vld_in, rd_en;
  logic [DW-1:0] din_0, din_1;
  logic [AW-1:0] rd_addr;

  logic [OW-1:0] a_d0, a_d1, b_d0, b_d1;
  logic [AW-1:0] a_cnt, b_cnt;
  logic          a_vld, a_bsy, a_done, a_ovf;
  logic          b_vld, b_bsy, b_done, b_ovf;

  l0_pool #(.DW(DW), .OW(OW), .SHIFT(0), .N_WIN(N_WIN), .AW(AW)) u_s0 (
    .clk(clk), .rst_n(rst_n), .tx_done(tx_done), .vld_in(vld_in),
    .din_0(din_0), .din_1(din_1), .rd_en(rd_en), .rd_addr(rd_addr),
    .dout_0(a_d0), .dout_1(a_d1), .rd_vld(a_vld), .wr_cnt(a_cnt),
    .bsy(a_bsy), .done(a_done), .ovf(a_ovf));

  l0_pool #(.DW(DW), .OW(OW), .SHIFT(4), .N_WIN(N_WIN), .AW(AW)) u_s4 (
    .clk(clk), .rst_n(rst_n), .tx_done(tx_done), .vld_in(vld_in),
    .din_0(din_0), .din_1(din_1), .rd_en(rd_en), .rd_addr(rd_addr),
    .dout_0(b_d0), .dout_1(b_d1), .rd_vld(b_vld), .wr_cnt(b_cnt),
    .bsy(b_bsy), .done(b_done), .ovf(b_ovf));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned quant(input logic [DW-1:0] m, input int unsigned s);
    int unsigned q;
    q = 32'(m) >> s;
    return (q > 255) ? 255 : q;
  endfunction

  // Reference model: window maxima indexed by pooled address.
  logic [DW-1:0] ref0 [N_WIN];
  logic [DW-1:0] ref1 [N_WIN];
  logic [DW-1:0] bq0[$], bq1[$];
  int unsigned   m_cnt  = 0;
  bit            m_done = 0;
  bit            m_ovf  = 0;

  typedef struct {
    bit            v;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } rexp_t;
  rexp_t sb[$];

  // Drive one cycle of inputs, advance the model for that edge, then return
  // 1 time unit after the edge.
  task automatic step(input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input bit re, input logic [AW-1:0] ra, input bit txd);
    rexp_t e;
    logic [DW-1:0] x0, x1;
    vld_in = v; din_0 = a; din_1 = b; rd_en = re; rd_addr = ra; tx_done = txd;
    if (re) begin
      e.v = !txd && (32'(ra) < m_cnt);
      e.a = e.v ? ref0[ra] : '0;
      e.b = e.v ? ref1[ra] : '0;
      sb.push_back(e);
    end
    if (txd) begin
      m_cnt = 0; m_done = 0; m_ovf = 0;
      bq0.delete(); bq1.delete();
    end else if (v) begin
      if (m_done) m_ovf = 1;
      else begin
        bq0.push_back(a); bq1.push_back(b);
        if (bq0.size() == 4) begin
          x0 = '0; x1 = '0;
          for (int i = 0; i < 4; i++) begin
            if (bq0[i] > x0) x0 = bq0[i];
            if (bq1[i] > x1) x1 = bq1[i];
          end
          ref0[m_cnt] = x0; ref1[m_cnt] = x1;
          m_cnt++;
          bq0.delete(); bq1.delete();
          if (m_cnt == N_WIN) m_done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    vld_in = 0; rd_en = 0; tx_done = 0;
  endtask

  task automatic chk_status();
    chk("wr_cnt_s0", a_cnt, m_cnt);
    chk("wr_cnt_s4", b_cnt, m_cnt);
    chk("done_s0", a_done, m_done);
    chk("done_s4", b_done, m_done);
    chk("ovf_s0", a_ovf, m_ovf);
    chk("ovf_s4", b_ovf, m_ovf);
    chk("bsy_s0", a_bsy, bq0.size() != 0);
    chk("bsy_s4", b_bsy, bq0.size() != 0);
  endtask

  // Monitor: compares the read port against the scoreboard.
  logic  rd_en_d = 1'b0;
  rexp_t mon_e;
  always @(posedge clk) rd_en_d <= rd_en;

  always @(negedge clk) begin
    if (rd_en_d) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty: got read response expected none queued at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("rd_vld_s0", a_vld, mon_e.v);
        chk("rd_vld_s4", b_vld, mon_e.v);
        chk("dout0_s0", a_d0, mon_e.v ? quant(mon_e.a, 0) : 0);
        chk("dout1_s0", a_d1, mon_e.v ? quant(mon_e.b, 0) : 0);
        chk("dout0_s4", b_d0, mon_e.v ? quant(mon_e.a, 4) : 0);
        chk("dout1_s4", b_d1, mon_e.v ? quant(mon_e.b, 4) : 0);
      end
    end else begin
      chk("rd_idle_s0", a_vld, 0);
      chk("rd_idle_s4", b_vld, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] r0, r1;
  logic [AW-1:0] ra;
  bit            re;

  initial begin
    rst_n = 0; tx_done = 0; vld_in = 0; rd_en = 0;
    din_0 = '0; din_1 = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_status();
    chk("rst_dout_s0", {a_d1, a_d0}, 0);
    chk("rst_dout_s4", {b_d1, b_d0}, 0);
    rst_n = 1;

    // Basic window: ch0 5,100,3,7 and ch1 0,0,0,9.
    step(1, 5, 0, 0, 0, 0);
    step(1, 100, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    chk_status();
    step(1, 7, 9, 0, 0, 0);
    chk_status();
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);

    // Saturation window.
    step(1, 18'h3FFFF, 18'h000FF, 0, 0, 0);
    step(1, 1, 18'h00010, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk_status();
    step(0, 0, 0, 1, 1, 0);

    // A partial window is discarded by tx_done.
    step(0, 0, 0, 0, 0, 1);
    step(1, 9, 9, 0, 0, 0);
    step(1, 8, 8, 0, 0, 0);
    chk_status();
    step(0, 0, 0, 0, 0, 1);
    chk_status();
    for (int i = 1; i <= 4; i++) step(1, DW'(i), DW'(i), 0, 0, 0);
    chk_status();
    step(0, 0, 0, 1, 0, 0);

    // Full image with random gaps and interleaved reads.
    step(0, 0, 0, 0, 0, 1);
    for (int w = 0; w < int'(N_WIN); w++) begin
      for (int bt = 0; bt < 4; bt++) begin
        if (bt == 0 && (w == 5 || w == 6)) step(0, 0, 0, 1, 5, 0);
        repeat ($urandom_range(0, 2)) begin
          re = 1'($urandom_range(0, 1));
          ra = AW'($urandom_range(0, N_WIN + 20));
          step(0, DW'($urandom), DW'($urandom), re, ra, 0);
        end
        r0 = DW'($urandom);
        r1 = DW'($urandom);
        if ($urandom_range(0, 1) == 1) r0 = r0 & 18'h00FFF;
        if ($urandom_range(0, 1) == 1) r1 = r1 & 18'h00FFF;
        re = 1'($urandom_range(0, 1));
        ra = AW'($urandom_range(0, N_WIN + 20));
        if (w == 5 && bt == 3) begin re = 1; ra = 5; end
        step(1, r0, r1, re, ra, 0);
        chk_status();
      end
    end
    for (int i = 0; i < int'(N_WIN); i++) step(0, 0, 0, 1, AW'(i), 0);
    step(0, 0, 0, 1, AW'(N_WIN), 0);

    // Samples arriving after done.
    repeat (3) step(1, 18'h3FFFF, 18'h3FFFF, 0, 0, 0);
    chk_status();
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk_status();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
